// File: rtl/register_scoreboard.sv
// Pending-write scoreboard for long-latency ops: issue marks rd pending, writeback clears it,
// decode gets a RAW/WAW/slot stall. Define SCOREBOARD_BYPASS_EN to unstall on the writeback cycle.
module register_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CountWidth     = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [REG_INDEX_WIDTH-1:0] issue_rd_index,
  input  logic                       writeback_valid,
  input  logic [REG_INDEX_WIDTH-1:0] writeback_rd_index,
  input  logic [REG_INDEX_WIDTH-1:0] rs1_index_decode,
  input  logic [REG_INDEX_WIDTH-1:0] rs2_index_decode,
  input  logic [REG_INDEX_WIDTH-1:0] rd_index_decode,
  input  logic                       long_latency_decode,
  output logic                       stall_pipeline,
  output logic                       issue_ready,
  output logic [CountWidth-1:0]      outstanding_count,
  output logic [NUM_REGS-1:0]        pending_mask,
  output logic                       protocol_error
);

  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  error_q, error_d;

  logic [NUM_REGS-1:0]   wb_hit, iss_hit, visible_pending;
  logic                  wb_accept, issue_accept, issue_busy, raw_or_waw;

  assign issue_ready = (count_q < MaxCount);

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wb_hit       = '0;
    iss_hit      = '0;
    wb_accept    = 1'b0;
    issue_accept = 1'b0;
    issue_busy   = 1'b0;
    error_d      = error_q;

    if (writeback_valid && writeback_rd_index != '0) begin
      wb_accept = pending_q[writeback_rd_index];
      wb_hit[writeback_rd_index] = pending_q[writeback_rd_index];
      if (!pending_q[writeback_rd_index]) error_d = 1'b1;
    end

    // A register may be re-issued in the very cycle its previous write retires.
    if (issue_valid && issue_rd_index != '0) begin
      issue_busy = pending_q[issue_rd_index] && !wb_hit[issue_rd_index];
      if (!issue_ready || issue_busy) begin
        error_d = 1'b1;
      end else begin
        issue_accept = 1'b1;
        iss_hit[issue_rd_index] = 1'b1;
      end
    end

    pending_d    = (pending_q & ~wb_hit) | iss_hit;
    pending_d[0] = 1'b0;
    count_d      = count_q + CountWidth'(issue_accept) - CountWidth'(wb_accept);
  end

`ifdef SCOREBOARD_BYPASS_EN
  assign visible_pending = pending_q & ~wb_hit;
`else
  assign visible_pending = pending_q;
`endif

  always_comb begin
    raw_or_waw = 1'b0;
    if (rs1_index_decode != '0 && visible_pending[rs1_index_decode]) raw_or_waw = 1'b1;
    if (rs2_index_decode != '0 && visible_pending[rs2_index_decode]) raw_or_waw = 1'b1;
    if (rd_index_decode  != '0 && visible_pending[rd_index_decode])  raw_or_waw = 1'b1;
  end

  assign stall_pipeline = raw_or_waw | (long_latency_decode & ~issue_ready);

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      error_q   <= error_d;
    end
  end

  assign pending_mask      = pending_q;
  assign outstanding_count = count_q;
  assign protocol_error    = error_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: event-level reference model feeds an expectation queue.
module tb_register_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd_index = '0;
  logic        writeback_valid = 1'b0;
  logic [4:0]  writeback_rd_index = '0;
  logic [4:0]  rs1_index_decode = '0;
  logic [4:0]  rs2_index_decode = '0;
  logic [4:0]  rd_index_decode = '0;
  logic        long_latency_decode = 1'b0;
  logic        stall_pipeline;
  logic        issue_ready;
  logic [2:0]  outstanding_count;
  logic [31:0] pending_mask;
  logic        protocol_error;

  register_scoreboard dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .issue_valid         (issue_valid),
    .issue_rd_index      (issue_rd_index),
    .writeback_valid     (writeback_valid),
    .writeback_rd_index  (writeback_rd_index),
    .rs1_index_decode    (rs1_index_decode),
    .rs2_index_decode    (rs2_index_decode),
    .rd_index_decode     (rd_index_decode),
    .long_latency_decode (long_latency_decode),
    .stall_pipeline      (stall_pipeline),
    .issue_ready         (issue_ready),
    .outstanding_count   (outstanding_count),
    .pending_mask        (pending_mask),
    .protocol_error      (protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pend;
    int          cnt;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  bit [31:0]   m_pend = '0;
  int          m_cnt  = 0;
  bit          m_err  = 1'b0;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit model_visible(input int r, input bit wv, input int wr);
    if (r == 0 || !m_pend[r]) return 1'b0;
    if (Bypass && wv && wr == r) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit rst, input bit iv, input int ir, input bit wv, input int wr,
                      input int s1, input int s2, input int d, input bit ll);
    exp_t e;
    bit   ready, hazard, wb_ok;
    @(negedge clk);
    rst_n               = ~rst;
    issue_valid         = iv;
    issue_rd_index      = 5'(ir);
    writeback_valid     = wv;
    writeback_rd_index  = 5'(wr);
    rs1_index_decode    = 5'(s1);
    rs2_index_decode    = 5'(s2);
    rd_index_decode     = 5'(d);
    long_latency_decode = ll;
    #1;
    ready  = (m_cnt < 4);
    hazard = model_visible(s1, wv, wr) || model_visible(s2, wv, wr) || model_visible(d, wv, wr);
    check("issue_ready", issue_ready, ready);
    check("stall_pipeline", stall_pipeline, hazard || (ll && !ready));

    if (rst) begin
      m_pend = '0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      wb_ok = wv && wr != 0 && m_pend[wr];
      if (wv && wr != 0 && !m_pend[wr]) m_err = 1'b1;
      if (wb_ok) begin
        m_pend[wr] = 1'b0;
        m_cnt--;
      end
      if (iv && ir != 0) begin
        if (!ready || m_pend[ir]) m_err = 1'b1;
        else begin
          m_pend[ir] = 1'b1;
          m_cnt++;
        end
      end
    end
    e.pend = m_pend;
    e.cnt  = m_cnt;
    e.err  = m_err;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pending_mask", pending_mask, e.pend);
    check("outstanding_count", {29'b0, outstanding_count}, e.cnt);
    check("protocol_error", {31'b0, protocol_error}, {31'b0, e.err});
  endtask

  task automatic idle(input int s1, input int s2, input int d, input bit ll);
    step(0, 0, 0, 0, 0, s1, s2, d, ll);
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Reset state, then a decode with nothing pending.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5, 6, 7, 0);
    check("idle_no_stall", {31'b0, stall_pipeline}, 32'd0);

    // RAW on r5 through its writeback.
    step(0, 1, 5, 0, 0, 0, 0, 0, 0);
    repeat (3) idle(5, 0, 0, 0);
    step(0, 0, 0, 1, 5, 5, 0, 0, 0);
    check("r5_cleared", {31'b0, pending_mask[5]}, 32'd0);
    idle(5, 0, 0, 0);
    check("r5_no_stall_after", {31'b0, stall_pipeline}, 32'd0);

    // Fill all slots, then overflow issue to r8.
    for (int r = 1; r <= 4; r++) step(0, 1, r, 0, 0, 0, 0, 0, 0);
    check("full_count", {29'b0, outstanding_count}, 32'd4);
    check("full_not_ready", {31'b0, issue_ready}, 32'd0);
    idle(0, 0, 0, 1);
    step(0, 1, 8, 0, 0, 0, 0, 0, 0);
    check("overflow_r8_clear", {31'b0, pending_mask[8]}, 32'd0);
    check("overflow_error", {31'b0, protocol_error}, 32'd1);

    // Same-register and different-register issue/writeback in one cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 3, 0, 0, 0, 0);
    check("same_reg_bit3", {31'b0, pending_mask[3]}, 32'd1);
    step(0, 1, 10, 1, 3, 0, 0, 3, 0);
    check("diff_reg_count", {29'b0, outstanding_count}, 32'd1);
    check("diff_reg_no_err", {31'b0, protocol_error}, 32'd0);
    step(0, 1, 10, 0, 0, 0, 10, 0, 0);
    check("reissue_pending_err", {31'b0, protocol_error}, 32'd1);

    // x0 issue is silent; writeback to a non-pending register is an error.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("x0_no_err", {31'b0, protocol_error}, 32'd0);
    check("x0_no_count", {29'b0, outstanding_count}, 32'd0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 9, 0, 0, 0, 0);
    check("wb_nonpending_err", {31'b0, protocol_error}, 32'd1);

    // Reset with three writes outstanding.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 11; r <= 13; r++) step(0, 1, r, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 11, 12, 13, 0);
    idle(11, 12, 13, 1);
    check("post_reset_stall", {31'b0, stall_pipeline}, 32'd0);

    // Random traffic over a small register window to exercise collisions.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0),
           $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
